// File: rtl/tick_strobe_rx_if.sv
// ============================================================================
// Module  : tick_strobe_rx_if
// Purpose : Bundle of the slow-tap input, its control inputs and the strobe
//           outputs of tick_strobe_rx.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface tick_strobe_rx_if #(
    parameter int DIV_W = 4,
    parameter int CNT_W = 16
);
    logic             div_in;
    logic [DIV_W-1:0] ratio;
    logic             pause;
    logic             tick_raw;
    logic             strobe;
    logic [CNT_W-1:0] strobe_cnt;
    logic             stall;

    modport master (
        output div_in, ratio, pause,
        input  tick_raw, strobe, strobe_cnt, stall
    );

    modport slave (
        input  div_in, ratio, pause,
        output tick_raw, strobe, strobe_cnt, stall
    );
endinterface

`default_nettype wire

// File: rtl/tick_strobe_rx.sv
// ============================================================================
// Module  : tick_strobe_rx
// Purpose : Synchronises a slow divided-clock tap into clk and turns its edges
//           into single-cycle enables, with sub-ratio, pause, strobe counter
//           and stall watchdog. Define BOTH_EDGE_EN to count both tap edges.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tick_strobe_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int DIV_W       = 4,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT     = 200000000
) (
    input  wire logic           clk,
    input  wire logic           rst,
    tick_strobe_rx_if.slave     bus
);
    localparam int c_tmr_w = $clog2(TIMEOUT + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_cur;
    logic                   r_prev;
    logic [SYNC_STAGES+1:0] r_vld;
    logic [DIV_W-1:0]       r_cnt;
    logic [c_tmr_w-1:0]     r_timer;
    logic                   r_tick;
    logic                   r_strobe;
    logic [CNT_W-1:0]       r_strobe_cnt;
    logic                   r_stall;

    logic                   w_raw;
    logic                   w_count_en;
    logic [DIV_W-1:0]       w_ratio_eff;
    logic                   w_fire;
    logic [c_tmr_w-1:0]     w_timer_next;

    // r_vld marks chain stages that hold a genuine post-reset sample, so a tap
    // held high through reset cannot fake a 0->1 edge against cleared flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_cur  <= 1'b0;
            r_prev <= 1'b0;
            r_vld  <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.div_in};
            r_cur  <= r_sync[SYNC_STAGES-1];
            r_prev <= r_cur;
            r_vld  <= {r_vld[SYNC_STAGES:0], 1'b1};
        end
    end

`ifdef BOTH_EDGE_EN
    assign w_raw = (r_cur ^ r_prev) & r_vld[SYNC_STAGES+1];
`else
    assign w_raw = r_cur & ~r_prev & r_vld[SYNC_STAGES+1];
`endif

    assign w_ratio_eff = (bus.ratio == '0) ? DIV_W'(1) : bus.ratio;
    assign w_count_en  = w_raw & ~bus.pause;
    // '>=' lets a ratio lowered mid-count fire on the next edge.
    assign w_fire      = w_count_en & (r_cnt >= (w_ratio_eff - DIV_W'(1)));

    always_comb begin
        w_timer_next = r_timer;
        if (w_raw) begin
            w_timer_next = '0;
        end else if (r_timer != c_tmr_w'(TIMEOUT)) begin
            w_timer_next = r_timer + c_tmr_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_timer      <= '0;
            r_tick       <= 1'b0;
            r_strobe     <= 1'b0;
            r_strobe_cnt <= '0;
            r_stall      <= 1'b0;
        end else begin
            r_tick   <= w_raw;
            r_strobe <= w_fire;
            r_timer  <= w_timer_next;
            r_stall  <= (w_timer_next == c_tmr_w'(TIMEOUT));
            if (w_count_en) begin
                r_cnt <= w_fire ? '0 : r_cnt + DIV_W'(1);
            end
            if (w_fire) begin
                r_strobe_cnt <= r_strobe_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.tick_raw   = r_tick;
    assign bus.strobe     = r_strobe;
    assign bus.strobe_cnt = r_strobe_cnt;
    assign bus.stall      = r_stall;

endmodule

`default_nettype wire

// File: tb/tb_tick_strobe_rx.sv
// ============================================================================
// Module  : tb_tick_strobe_rx
// Purpose : Directed plus randomized bench for tick_strobe_rx against a
//           sample-history reference model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tick_strobe_rx;
    localparam int SS    = 2;
    localparam int DIV_W = 4;
    localparam int CNT_W = 6;
    localparam int TO    = 50;
    localparam int HL    = SS + 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tick_strobe_rx_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

    tick_strobe_rx #(
        .SYNC_STAGES (SS),
        .DIV_W       (DIV_W),
        .CNT_W       (CNT_W),
        .TIMEOUT     (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int errors  = 0;

    // Model state: tap samples taken at each edge (2 = not a real sample).
    int hist [HL];
    int m_ticks_since;
    int m_scnt;
    int m_idle;
    bit m_tick, m_strobe, m_stall;

    logic             cur_pause = 1'b0;
    logic [DIV_W-1:0] cur_ratio = 4'd1;

    int obs_ticks   = 0;
    int obs_strobes = 0;
    int obs_stall   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic d, input logic rs);
        int eff;
        bus.div_in = d;
        bus.pause  = cur_pause;
        bus.ratio  = cur_ratio;
        rst        = rs;
        @(posedge clk);
        #1;
        if (rs) begin
            foreach (hist[i]) hist[i] = 2;
            m_tick = 0; m_strobe = 0; m_stall = 0;
            m_ticks_since = 0; m_scnt = 0; m_idle = 0;
        end else begin
            for (int i = 0; i < HL - 1; i++) hist[i] = hist[i+1];
            hist[HL-1] = int'(d);
`ifdef BOTH_EDGE_EN
            m_tick = (hist[1] != 2) && (hist[0] != 2) && (hist[1] != hist[0]);
`else
            m_tick = (hist[1] == 1) && (hist[0] == 0);
`endif
            m_strobe = 0;
            if (m_tick && !cur_pause) begin
                eff = (cur_ratio == 0) ? 1 : int'(cur_ratio);
                if (m_ticks_since + 1 >= eff) begin
                    m_strobe      = 1;
                    m_ticks_since = 0;
                    m_scnt        = (m_scnt + 1) % (1 << CNT_W);
                end else begin
                    m_ticks_since++;
                end
            end
            m_idle  = m_tick ? 0 : ((m_idle >= TO) ? TO : m_idle + 1);
            m_stall = (m_idle == TO);
        end
        chk("tick_raw",   32'(bus.tick_raw),   32'(m_tick));
        chk("strobe",     32'(bus.strobe),     32'(m_strobe));
        chk("strobe_cnt", 32'(bus.strobe_cnt), 32'(m_scnt));
        chk("stall",      32'(bus.stall),      32'(m_stall));
        obs_ticks   += int'(bus.tick_raw === 1'b1);
        obs_strobes += int'(bus.strobe === 1'b1);
        obs_stall   += int'(bus.stall === 1'b1);
    endtask

    task automatic pulse(input int hi, input int lo);
        repeat (hi) step(1'b1, 1'b0);
        repeat (lo) step(1'b0, 1'b0);
    endtask

    initial begin
        int t0, s0, c0;
        bus.div_in = 1'b0;
        bus.pause  = 1'b0;
        bus.ratio  = 4'd1;

        // Reset with the tap toggling; then tap held high must not tick.
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        t0 = obs_ticks;
        repeat (8) step(1'b1, 1'b0);
        chk("no_tick_held_high", 32'(obs_ticks - t0), 32'd0);

        // Latency: tick and strobe exactly SS+1 edges after first high sample.
        repeat (4) step(1'b0, 1'b0);
        c0 = int'(bus.strobe_cnt);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("latency_no_early", 32'(bus.tick_raw), 32'd0);
        step(1'b1, 1'b0);
        chk("latency_tick", 32'(bus.tick_raw), 32'd1);
        chk("latency_strobe", 32'(bus.strobe), 32'd1);
        step(1'b1, 1'b0);
        chk("tick_single", 32'(bus.tick_raw), 32'd0);
        chk("cnt_0_to_1", 32'(bus.strobe_cnt), 32'(c0 + 1));
        repeat (4) step(1'b0, 1'b0);

        // ratio=3 over 9 edges, then ratio=0 over 4 edges.
        cur_ratio = 4'd3;
        t0 = obs_ticks; s0 = obs_strobes;
        repeat (9) pulse(3, 4);
        chk("r3_ticks", 32'(obs_ticks - t0), 32'd9);
        chk("r3_strobes", 32'(obs_strobes - s0), 32'd3);
        cur_ratio = 4'd0;
        s0 = obs_strobes;
        repeat (4) pulse(3, 4);
        chk("r0_strobes", 32'(obs_strobes - s0), 32'd4);

        // ratio lowered mid-count fires on the next edge.
        cur_ratio = 4'd5;
        s0 = obs_strobes;
        repeat (3) pulse(3, 4);
        cur_ratio = 4'd2;
        pulse(3, 4);
        chk("ratio_lowered", 32'(obs_strobes - s0), 32'd1);

        // Pause: ticks continue, no strobes, release creates none.
        cur_ratio = 4'd2;
        pulse(3, 4);
        cur_pause = 1'b1;
        t0 = obs_ticks; s0 = obs_strobes;
        repeat (4) pulse(3, 4);
        chk("pause_ticks", 32'(obs_ticks - t0), 32'd4);
        chk("pause_strobes", 32'(obs_strobes - s0), 32'd0);
        cur_pause = 1'b0;
        repeat (6) step(1'b0, 1'b0);
        chk("unpause_no_strobe", 32'(obs_strobes - s0), 32'd0);
        pulse(3, 4);
        chk("unpause_held_cnt", 32'(obs_strobes - s0), 32'd1);

        // Watchdog: long low period raises stall, next rise clears it.
        s0 = obs_stall;
        pulse(3, TO + 15);
        chk("stall_seen", 32'(bus.stall), 32'd1);
        pulse(4, 2);
        chk("stall_cleared", 32'(bus.stall), 32'd0);

        // strobe_cnt wrap at 2^CNT_W.
        cur_ratio = 4'd1;
        repeat ((1 << CNT_W) + 6) pulse(2, 2);

        // Randomized segments, including one mid-run reset.
        for (int k = 0; k < 300; k++) begin
            cur_ratio = DIV_W'($urandom_range(0, 15));
            cur_pause = ($urandom_range(0, 3) == 0);
            if (k == 150) begin
                step(1'($urandom_range(0, 1)), 1'b1);
                step(1'($urandom_range(0, 1)), 1'b1);
            end
            pulse($urandom_range(1, 6), $urandom_range(1, 6));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

`default_nettype wire
